// File: rtl/gray_counter_ctrl_if.sv
// ----------------------------------------------------------------------------
// gray_counter_ctrl_if
//
// Purpose: groups the command port, the abort request and the counter status
// outputs of gray_counter_ctrl into one bundle. Clock and reset are left out
// and stay plain ports on the modules.
//
// Signals:
//   cmd_valid  host -> ctrl  command present
//   cmd_ready  ctrl -> host  command accepted when cmd_valid && cmd_ready
//   cmd_op     host -> ctrl  00 START, 01 STEP, 10 LOAD, 11 reserved
//   cmd_data   host -> ctrl  START: limit, LOAD: binary load value
//   abort      host -> ctrl  synchronous stop request
//   gray_out   ctrl -> host  Gray-coded count
//   bin_out    ctrl -> host  binary count
//   busy       ctrl -> host  controller not idle
//   done       ctrl -> host  one-cycle completion pulse
//
// Modports: master (host side), slave (controller side).
// ----------------------------------------------------------------------------
interface gray_counter_ctrl_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic                  abort;
   logic [DATA_WIDTH-1:0] gray_out;
   logic [DATA_WIDTH-1:0] bin_out;
   logic                  busy;
   logic                  done;

   modport master (
      output cmd_valid, cmd_op, cmd_data, abort,
      input  cmd_ready, gray_out, bin_out, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, abort,
      output cmd_ready, gray_out, bin_out, busy, done
   );

endinterface

// File: rtl/gray_counter_ctrl.sv
// ----------------------------------------------------------------------------
// gray_counter_ctrl
//
// Purpose: command-driven sequencer for a binary counter whose value is also
// presented in Gray code. LOAD and STEP change the count directly while idle;
// START records a limit and counts up to it, wrapping through all-ones to
// zero if needed, then raises done for one cycle. abort stops a run without
// a done pulse.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of gray_counter_ctrl_if (command port, abort,
//          gray_out, bin_out, busy, done)
//
// Parameters:
//   DATA_WIDTH  counter and command data width (>= 2)
//
// Build option:
//   GRAY_CTRL_REPEAT_EN  when defined, DONE reloads the count captured at
//                        START and runs the same sequence again until abort.
//                        When undefined, DONE always returns to IDLE.
// ----------------------------------------------------------------------------
module gray_counter_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   gray_counter_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STEP  = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;

   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] bin;
   logic [DATA_WIDTH-1:0] limit;

`ifdef GRAY_CTRL_REPEAT_EN
   logic [DATA_WIDTH-1:0] start_val;
`endif

   // Main sequencer. Commands are only taken in IDLE, which is exactly when
   // cmd_ready is high, so no separate handshake check on ready is needed.
   // In RUN, abort wins over reaching the limit, and reaching the limit wins
   // over incrementing, so the count freezes at the limit for the DONE cycle.
   // Plain modulo addition gives the wrap through all-ones to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bin       <= '0;
         limit     <= '0;
`ifdef GRAY_CTRL_REPEAT_EN
         start_val <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  case (bus.cmd_op)
                     OP_LOAD: bin <= bus.cmd_data;
                     OP_STEP: bin <= bin + ONE;
                     OP_START: begin
                        limit     <= bus.cmd_data;
`ifdef GRAY_CTRL_REPEAT_EN
                        start_val <= bin;
`endif
                        state     <= ST_RUN;
                     end
                     default: ;
                  endcase
               end
            end

            ST_RUN: begin
               if (bus.abort) begin
                  state <= ST_IDLE;
               end else if (bin == limit) begin
                  state <= ST_DONE;
               end else begin
                  bin <= bin + ONE;
               end
            end

            ST_DONE: begin
`ifdef GRAY_CTRL_REPEAT_EN
               if (bus.abort) begin
                  state <= ST_IDLE;
               end else begin
                  state <= ST_RUN;
                  bin   <= start_val;
               end
`else
               state <= ST_IDLE;
`endif
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   // Status and count outputs are decoded straight from the registers, so
   // a reset shows up on them without waiting for a clock edge.
   always_comb begin
      bus.cmd_ready = (state == ST_IDLE);
      bus.busy      = (state != ST_IDLE);
      bus.done      = (state == ST_DONE);
      bus.bin_out   = bin;
      bus.gray_out  = bin ^ (bin >> 1);
   end

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gray_counter_ctrl
//
// Purpose: directed self-checking bench for gray_counter_ctrl with an 8-bit
// counter. Each scenario task drives its own commands and compares the
// outputs against hand-computed values one cycle at a time.
//
// Build option: GRAY_CTRL_REPEAT_EN selects the repeating-run scenario in
// place of the single-pass scenarios.
// ----------------------------------------------------------------------------
module tb_gray_counter_ctrl;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STEP  = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   logic clk;
   logic rst_n;
   int   pass_count;
   int   check_count;

   gray_counter_ctrl_if #(.DATA_WIDTH(8)) bus ();

   gray_counter_ctrl #(.DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case some scenario never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge, where outputs are sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command once the controller is ready and hold it for
   // exactly the accepting edge.
   task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] data);
      int n;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (bus.cmd_ready !== 1'b1) begin
         check_count++;
         $display("[TB] FAIL ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Power-on reset: outputs are at their reset values before any edge.
   task automatic test_reset();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = 8'h00;
      bus.abort     = 1'b0;
      rst_n         = 1'b0;
      #3;
      check_count++;
      if ({bus.gray_out, bus.bin_out, bus.busy, bus.done, bus.cmd_ready} !== {8'h00, 8'h00, 3'b001}) begin
         $display("[TB] FAIL reset_outputs: gray=%h bin=%h busy=%b done=%b ready=%b required 00 00 0 0 1",
                  bus.gray_out, bus.bin_out, bus.busy, bus.done, bus.cmd_ready);
      end else pass_count++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Reset in the middle of a run clears everything without waiting for a clock.
   task automatic test_reset_mid_run();
      apply_stimulus(OP_LOAD, 8'h10);
      apply_stimulus(OP_START, 8'h50);
      repeat (3) tick();
      check_count++;
      if (bus.bin_out !== 8'h13 || bus.busy !== 1'b1) begin
         $display("[TB] FAIL pre_reset_run: bin=%h busy=%b required 13 1", bus.bin_out, bus.busy);
      end else pass_count++;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_count++;
      if ({bus.gray_out, bus.bin_out, bus.busy, bus.done, bus.cmd_ready} !== {8'h00, 8'h00, 3'b001}) begin
         $display("[TB] FAIL reset_mid_run: gray=%h bin=%h busy=%b done=%b ready=%b required 00 00 0 0 1",
                  bus.gray_out, bus.bin_out, bus.busy, bus.done, bus.cmd_ready);
      end else pass_count++;
      tick();
      check_count++;
      if (bus.done !== 1'b0 || bus.bin_out !== 8'h00) begin
         $display("[TB] FAIL reset_held: done=%b bin=%h required 0 00", bus.done, bus.bin_out);
      end else pass_count++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Back-to-back LOAD/STEP/reserved, with abort high in IDLE having no effect.
   task automatic test_back_to_back();
      logic [1:0] ops  [0:3];
      logic [7:0] dats [0:3];
      logic       abts [0:3];
      logic [7:0] expb [0:3];
      ops  = '{OP_LOAD, OP_STEP, OP_RSVD, OP_STEP};
      dats = '{8'h05, 8'hAA, 8'hFF, 8'h00};
      abts = '{1'b0, 1'b1, 1'b0, 1'b1};
      expb = '{8'h05, 8'h06, 8'h06, 8'h07};
      for (int i = 0; i < 4; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = ops[i];
         bus.cmd_data  = dats[i];
         bus.abort     = abts[i];
         tick();
         check_count++;
         if (bus.bin_out !== expb[i] || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL back_to_back[%0d]: bin=%h ready=%b busy=%b required %h 1 0",
                     i, bus.bin_out, bus.cmd_ready, bus.busy, expb[i]);
         end else pass_count++;
      end
      bus.cmd_valid = 1'b0;
      bus.abort     = 1'b0;
   endtask

`ifndef GRAY_CTRL_REPEAT_EN
   // LOAD 0x0A, START 0x0D: three increments, DONE, then ready again.
   task automatic test_count_up();
      logic [7:0] expg [0:3];
      expg = '{8'h0F, 8'h0E, 8'h0A, 8'h0B};
      apply_stimulus(OP_LOAD, 8'h0A);
      check_count++;
      if (bus.bin_out !== 8'h0A || bus.cmd_ready !== 1'b1) begin
         $display("[TB] FAIL load_0a: bin=%h ready=%b required 0a 1", bus.bin_out, bus.cmd_ready);
      end else pass_count++;
      apply_stimulus(OP_START, 8'h0D);
      for (int i = 0; i < 4; i++) begin
         check_count++;
         if (bus.gray_out !== expg[i] || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            $display("[TB] FAIL count_up[%0d]: gray=%h busy=%b done=%b ready=%b required %h 1 0 0",
                     i, bus.gray_out, bus.busy, bus.done, bus.cmd_ready, expg[i]);
         end else pass_count++;
         tick();
      end
      check_count++;
      if (bus.done !== 1'b1 || bus.bin_out !== 8'h0D || bus.cmd_ready !== 1'b0) begin
         $display("[TB] FAIL count_up_done: done=%b bin=%h ready=%b required 1 0d 0",
                  bus.done, bus.bin_out, bus.cmd_ready);
      end else pass_count++;
      tick();
      check_count++;
      if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.bin_out !== 8'h0D) begin
         $display("[TB] FAIL count_up_idle: done=%b ready=%b busy=%b bin=%h required 0 1 0 0d",
                  bus.done, bus.cmd_ready, bus.busy, bus.bin_out);
      end else pass_count++;
   endtask

   // LOAD 0xFE, START 0x01: wraps through 0xFF -> 0x00 with single-bit Gray steps.
   task automatic test_wrap();
      logic [7:0] expb [0:3];
      logic [7:0] expg [0:3];
      int         done_seen;
      expb = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      expg = '{8'h81, 8'h80, 8'h00, 8'h01};
      done_seen = 0;
      apply_stimulus(OP_LOAD, 8'hFE);
      apply_stimulus(OP_START, 8'h01);
      for (int i = 0; i < 4; i++) begin
         check_count++;
         if (bus.bin_out !== expb[i] || bus.gray_out !== expg[i]) begin
            $display("[TB] FAIL wrap[%0d]: bin=%h gray=%h required %h %h",
                     i, bus.bin_out, bus.gray_out, expb[i], expg[i]);
         end else pass_count++;
         if (bus.done === 1'b1) done_seen++;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         if (bus.done === 1'b1) done_seen++;
         tick();
      end
      check_count++;
      if (done_seen !== 1 || bus.cmd_ready !== 1'b1 || bus.bin_out !== 8'h01) begin
         $display("[TB] FAIL wrap_done: done_pulses=%0d ready=%b bin=%h required 1 1 01",
                  done_seen, bus.cmd_ready, bus.bin_out);
      end else pass_count++;
   endtask

   // Abort at bin 0x25 of a 0x20 -> 0x40 run: count freezes, no done pulse.
   task automatic test_abort();
      int done_seen;
      done_seen = 0;
      apply_stimulus(OP_LOAD, 8'h20);
      apply_stimulus(OP_START, 8'h40);
      for (int i = 0; i < 5; i++) begin
         if (bus.done === 1'b1) done_seen++;
         tick();
      end
      check_count++;
      if (bus.bin_out !== 8'h25 || bus.busy !== 1'b1) begin
         $display("[TB] FAIL abort_pre: bin=%h busy=%b required 25 1", bus.bin_out, bus.busy);
      end else pass_count++;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_count++;
      if (bus.bin_out !== 8'h25 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         $display("[TB] FAIL abort_stop: bin=%h busy=%b done=%b ready=%b required 25 0 0 1",
                  bus.bin_out, bus.busy, bus.done, bus.cmd_ready);
      end else pass_count++;
      for (int i = 0; i < 3; i++) begin
         if (bus.done === 1'b1) done_seen++;
         tick();
      end
      check_count++;
      if (done_seen !== 0 || bus.bin_out !== 8'h25) begin
         $display("[TB] FAIL abort_quiet: done_pulses=%0d bin=%h required 0 25", done_seen, bus.bin_out);
      end else pass_count++;
      apply_stimulus(OP_STEP, 8'h00);
      check_count++;
      if (bus.bin_out !== 8'h26) begin
         $display("[TB] FAIL abort_step: bin=%h required 26", bus.bin_out);
      end else pass_count++;
   endtask

   // START with limit equal to the count, with a LOAD held on the port
   // through RUN and DONE that must not be taken.
   task automatic test_limit_equal();
      apply_stimulus(OP_LOAD, 8'h33);
      apply_stimulus(OP_START, 8'h33);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = 8'h77;
      check_count++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bin_out !== 8'h33 || bus.cmd_ready !== 1'b0) begin
         $display("[TB] FAIL equal_run: busy=%b done=%b bin=%h ready=%b required 1 0 33 0",
                  bus.busy, bus.done, bus.bin_out, bus.cmd_ready);
      end else pass_count++;
      tick();
      check_count++;
      if (bus.done !== 1'b1 || bus.bin_out !== 8'h33 || bus.cmd_ready !== 1'b0) begin
         $display("[TB] FAIL equal_done: done=%b bin=%h ready=%b required 1 33 0",
                  bus.done, bus.bin_out, bus.cmd_ready);
      end else pass_count++;
      tick();
      bus.cmd_valid = 1'b0;
      check_count++;
      if (bus.done !== 1'b0 || bus.bin_out !== 8'h33 || bus.cmd_ready !== 1'b1) begin
         $display("[TB] FAIL equal_idle: done=%b bin=%h ready=%b required 0 33 1",
                  bus.done, bus.bin_out, bus.cmd_ready);
      end else pass_count++;
   endtask
`else
   // Repeating run 0 -> 2: DONE reloads the start value every four cycles.
   task automatic test_repeat();
      logic [7:0] expb [0:7];
      logic       expd [0:7];
      expb = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h00, 8'h01, 8'h02, 8'h02};
      expd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      apply_stimulus(OP_LOAD, 8'h00);
      apply_stimulus(OP_START, 8'h02);
      for (int i = 0; i < 8; i++) begin
         check_count++;
         if (bus.bin_out !== expb[i] || bus.done !== expd[i] || bus.cmd_ready !== 1'b0) begin
            $display("[TB] FAIL repeat[%0d]: bin=%h done=%b ready=%b required %h %b 0",
                     i, bus.bin_out, bus.done, bus.cmd_ready, expb[i], expd[i]);
         end else pass_count++;
         tick();
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_count++;
      if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.bin_out !== 8'h00) begin
         $display("[TB] FAIL repeat_abort: ready=%b busy=%b bin=%h required 1 0 00",
                  bus.cmd_ready, bus.busy, bus.bin_out);
      end else pass_count++;
   endtask
`endif

   // Scenario sequence and summary.
   initial begin
      pass_count  = 0;
      check_count = 0;
      test_reset();
      test_back_to_back();
`ifndef GRAY_CTRL_REPEAT_EN
      test_count_up();
      test_wrap();
      test_abort();
      test_limit_equal();
`else
      test_repeat();
`endif
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/gray_counter_ctrl.md
# gray_counter_ctrl

Command-driven sequencer for an 8-bit (parameterizable) binary counter with Gray-coded output. It accepts LOAD/STEP/START commands over a valid/ready port and runs the counter up to a programmed limit, with wrap-around. It signals completion with a one-cycle pulse and supports a synchronous abort. It sits between a host/config interface and any consumer of a Gray-coded count (clock-domain pointers, position encoders).

## Interface
- DATA_WIDTH, 8, counter and command data width (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk edge
- cmd_op  in  2  00 START, 01 STEP, 10 LOAD, 11 reserved
- cmd_data  in  DATA_WIDTH  START: limit; LOAD: binary load value; else ignored
- abort  in  1  synchronous stop request, level-sampled each edge
- gray_out  out  DATA_WIDTH  bin ^ (bin >> 1) of internal binary count register
- bin_out  out  DATA_WIDTH  internal binary count register
- busy  out  1  state != IDLE
- done  out  1  high exactly while state == DONE

## Operation
- Registers: bin (DATA_WIDTH), limit (DATA_WIDTH), start_val (DATA_WIDTH), state {IDLE, RUN, DONE}.
- Reset: state=IDLE, bin=0, limit=0, start_val=0. Outputs: gray_out=0, bin_out=0, busy=0, done=0, cmd_ready=1.
- cmd_ready = (state == IDLE); combinational from state only.
- IDLE, accepted command:
  - LOAD: bin <= cmd_data; stay IDLE.
  - STEP: bin <= bin+1 mod 2^DATA_WIDTH; stay IDLE.
  - START: limit <= cmd_data, start_val <= bin; go to RUN.
  - reserved: consumed, no effect.
- abort is ignored in IDLE.
- RUN, per edge, in priority order:
  - abort=1: go to IDLE; bin holds; no done.
  - bin == limit: go to DONE; bin holds.
  - otherwise: bin <= bin+1 mod 2^DATA_WIDTH.
- A limit below the current bin wraps through 2^DATA_WIDTH−1 → 0.
- A limit equal to the current bin gives zero increments.
- DONE lasts one cycle with done=1. Next state is IDLE, or RUN per Configuration. abort in DONE forces IDLE; done still high that cycle.
- gray_out/bin_out are purely combinational from bin. Consecutive gray_out values in RUN differ in exactly one bit, including across wrap.

## Timing
- Edge k accepts START with bin=B, limit L=B+n (mod 2^W).
- Edges k+1..k+n increment bin, so bin=L after edge k+n.
- Edge k+n+1 enters DONE; done=1 for that cycle.
- Edge k+n+2 returns to IDLE; cmd_ready=1 after it.
- Total START-to-ready latency: n+2 cycles.
- LOAD/STEP: bin updates at the accepting edge; cmd_ready stays 1, so back-to-back commands run one per cycle.
- abort sampled at edge j in RUN: bin frozen at its pre-edge value; busy=0 after edge j.
- Asynchronous reset at any point (mid-RUN, DONE) returns all registers to reset values immediately. No done pulse is generated.

## Configuration
- GRAY_CTRL_REPEAT_EN defined:
  - DONE → RUN with bin <= start_val, repeating the same sequence indefinitely.
  - done pulses once per pass; the period is n+2 cycles.
  - Only abort (or reset) returns to IDLE; cmd_ready stays 0 throughout.
- GRAY_CTRL_REPEAT_EN undefined: DONE → IDLE always. start_val may be optimized away.

## Test plan
- Reset: assert rst_n=0 mid-RUN → gray_out=0, bin_out=0, busy=0, done=0, cmd_ready=1 immediately.
- LOAD 0x0A, START limit 0x0D → gray_out 0x0F, 0x0E, 0x0A, 0x0B on successive cycles. done=1 one cycle after bin=0x0D; cmd_ready=1 five cycles after START acceptance.
- LOAD 0xFE, START limit 0x01 → bin 0xFE, 0xFF, 0x00, 0x01; gray_out single-bit changes across wrap (0x81 → 0x80 → 0x00 → 0x01); done once.
- LOAD 0x20, START limit 0x40, abort when bin=0x25 → bin holds 0x25, busy=0 next cycle, done never asserted. A later STEP yields bin=0x26.
- START with limit == bin (0x33) → RUN one cycle, DONE one cycle, bin stays 0x33. cmd_valid held during RUN/DONE is not accepted.
- With GRAY_CTRL_REPEAT_EN: LOAD 0x00, START limit 0x02 → done every 4 cycles, bin sequence 0,1,2,2,0,1,2,2…. Abort → IDLE with cmd_ready=1.
